// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// fault-cause codes and the reset instruction.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_HOLD  = 3'd2,
    ST_FAULT = 3'd3,
    ST_DRAIN = 3'd4
  } fetch_state_e;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISALIGN = 2'd1;
  localparam logic [1:0] FC_BUSERR   = 2'd2;
  localparam logic [1:0] FC_TIMEOUT  = 2'd3;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Instruction fetches must be word aligned.
  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction memory port: single-outstanding request/ready transaction.
interface inst_fetch_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_rdata,
    input  mem_err
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_rdata,
    output mem_err
  );

endinterface

// File: rtl/inst_fetch_timer.sv
// Wait counter for an outstanding memory request. 'expired' flags the
// cycle in which the count reaches MAX_WAIT, so the caller can leave the
// waiting state on that same edge (MAX_WAIT not-ready cycles in total).
module fetch_timer #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Next count and expiry detection.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 8'd0;
    end else if (en) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
    expired = en && !clr && (count_d == LIMIT);
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: takes a PC on request, runs one memory
// transaction, and holds the instruction (or a fault) for decode.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned MAX_WAIT   = 255,
  parameter logic [31:0] RESET_INST = NOP_INST
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_start,
  input  logic [31:0]         pc_in,
  input  logic                flush,
  input  logic                inst_ack,
  inst_fetch_if.master        mem,
  output logic                inst_valid,
  output logic [31:0]         inst_out,
  output logic [31:0]         inst_pc,
  output logic                fetch_fault,
  output logic [1:0]          fault_cause,
  output logic                busy
);

  fetch_state_e state_q, state_d;
  logic         mem_req_q, mem_req_d;
  logic [31:0]  mem_addr_q, mem_addr_d;
  logic         inst_valid_q, inst_valid_d;
  logic [31:0]  inst_out_q, inst_out_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic         fetch_fault_q, fetch_fault_d;
  logic [1:0]   fault_cause_q, fault_cause_d;
  logic         busy_q, busy_d;

  logic         waiting_s;
  logic         tmr_en_s;
  logic         tmr_clr_s;
  logic         tmr_expired_s;
  logic         pc_ok_s;
  fetch_state_e start_state_s;
  logic [31:0]  start_addr_s;
  logic [1:0]   start_cause_s;
  logic [1:0]   cause_s;

  // The wait counter runs only while a request is on the bus (REQ or DRAIN).
  always_comb begin
    waiting_s = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    tmr_en_s  = waiting_s && !mem.mem_ready;
    tmr_clr_s = !waiting_s;
  end

  fetch_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmr_clr_s),
    .en      (tmr_en_s),
    .expired (tmr_expired_s)
  );

  // Outcome of accepting a fetch request for the current pc_in.
  always_comb begin
    pc_ok_s       = is_aligned(pc_in);
    start_state_s = pc_ok_s ? ST_REQ : ST_FAULT;
    start_addr_s  = pc_ok_s ? pc_in : mem_addr_q;
    start_cause_s = pc_ok_s ? FC_NONE : FC_MISALIGN;
  end

  // Next state and next register values; flush > ready/timeout > ack > start.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    inst_out_d = inst_out_q;
    inst_pc_d  = inst_pc_q;
    cause_s    = fault_cause_q;

    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (fetch_start) begin
          state_d    = start_state_s;
          mem_addr_d = start_addr_s;
          inst_pc_d  = pc_in;
          cause_s    = start_cause_s;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        if (flush) begin
          // A transaction that completes or times out this cycle needs no drain.
          state_d = (mem.mem_ready || tmr_expired_s) ? ST_IDLE : ST_DRAIN;
        end else if (mem.mem_ready) begin
          if (mem.mem_err) begin
            state_d = ST_FAULT;
            cause_s = FC_BUSERR;
          end else begin
            state_d    = ST_HOLD;
            inst_out_d = mem.mem_rdata;
          end
        end else if (tmr_expired_s) begin
          state_d = ST_FAULT;
          cause_s = FC_TIMEOUT;
        end else begin
          state_d = ST_REQ;
        end
      end

      ST_HOLD: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (inst_ack) begin
          if (fetch_start) begin
            state_d    = start_state_s;
            mem_addr_d = start_addr_s;
            inst_pc_d  = pc_in;
            cause_s    = start_cause_s;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end

      ST_FAULT: begin
        if (flush || inst_ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FAULT;
        end
      end

      ST_DRAIN: begin
        if (mem.mem_ready || tmr_expired_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cause_s = FC_NONE;
      end
    endcase

    fault_cause_d = (state_d == ST_FAULT) ? cause_s : FC_NONE;
    mem_req_d     = (state_d == ST_REQ) || (state_d == ST_DRAIN);
    inst_valid_d  = (state_d == ST_HOLD);
    fetch_fault_d = (state_d == ST_FAULT);
    busy_d        = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= 32'd0;
      inst_valid_q  <= 1'b0;
      inst_out_q    <= RESET_INST;
      inst_pc_q     <= 32'd0;
      fetch_fault_q <= 1'b0;
      fault_cause_q <= FC_NONE;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      inst_valid_q  <= inst_valid_d;
      inst_out_q    <= inst_out_d;
      inst_pc_q     <= inst_pc_d;
      fetch_fault_q <= fetch_fault_d;
      fault_cause_q <= fault_cause_d;
      busy_q        <= busy_d;
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign inst_valid   = inst_valid_q;
  assign inst_out     = inst_out_q;
  assign inst_pc      = inst_pc_q;
  assign fetch_fault  = fetch_fault_q;
  assign fault_cause  = fault_cause_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a transaction-level reference model
// checked every cycle, plus literal expectations at key points.
module tb_inst_fetch;

  localparam int unsigned MW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_start;
  logic [31:0] pc_in;
  logic        flush;
  logic        inst_ack;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        fetch_fault;
  logic [1:0]  fault_cause;
  logic        busy;
  logic        cmp_on = 1'b0;

  int errors = 0;
  int checks = 0;

  inst_fetch_if mem_if ();

  inst_fetch #(
    .MAX_WAIT   (MW),
    .RESET_INST (32'h0000_0013)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_start (fetch_start),
    .pc_in       (pc_in),
    .flush       (flush),
    .inst_ack    (inst_ack),
    .mem         (mem_if),
    .inst_valid  (inst_valid),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc),
    .fetch_fault (fetch_fault),
    .fault_cause (fault_cause),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model. phase: 0 idle, 1 request out, 2 instruction held,
  // 3 fault held, 4 request out but result will be thrown away.
  typedef struct {
    int          phase;
    int          waited;
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [1:0]  cause;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_reset();
    mstate_t r;
    r.phase = 0; r.waited = 0; r.addr = 32'd0;
    r.inst = 32'h0000_0013; r.pc = 32'd0; r.cause = 2'd0;
    return r;
  endfunction

  function automatic mstate_t start_fetch(input mstate_t s);
    mstate_t n = s;
    n.pc = pc_in;
    if (pc_in % 4 == 0) begin
      n.addr = pc_in; n.phase = 1; n.waited = 0;
    end else begin
      n.phase = 3; n.cause = 2'd1;
    end
    return n;
  endfunction

  function automatic mstate_t model_next(input mstate_t s);
    mstate_t n = s;
    case (s.phase)
      0: if (!flush && fetch_start) n = start_fetch(s);
      1: begin
        if (mem_if.mem_ready) begin
          if (flush) n.phase = 0;
          else if (mem_if.mem_err) begin n.phase = 3; n.cause = 2'd2; end
          else begin n.phase = 2; n.inst = mem_if.mem_rdata; end
        end else begin
          n.waited = s.waited + 1;
          if (n.waited == int'(MW)) begin
            n.phase = flush ? 0 : 3;
            if (!flush) n.cause = 2'd3;
          end else if (flush) n.phase = 4;
        end
      end
      2: begin
        if (flush) n.phase = 0;
        else if (inst_ack) begin
          n.phase = 0;
          if (fetch_start) n = start_fetch(n);
        end
      end
      3: if (flush || inst_ack) begin n.phase = 0; n.cause = 2'd0; end
      4: begin
        if (mem_if.mem_ready) n.phase = 0;
        else begin
          n.waited = s.waited + 1;
          if (n.waited == int'(MW)) n.phase = 0;
        end
      end
      default: n = model_reset();
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= model_reset();
    else        m <= model_next(m);
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_req",   32'(mem_if.mem_req), 32'(m.phase == 1 || m.phase == 4));
      chk("m_addr",  mem_if.mem_addr, m.addr);
      chk("m_valid", 32'(inst_valid), 32'(m.phase == 2));
      chk("m_inst",  inst_out, m.inst);
      chk("m_pc",    inst_pc, m.pc);
      chk("m_fault", 32'(fetch_fault), 32'(m.phase == 3));
      chk("m_cause", 32'(fault_cause), 32'((m.phase == 3) ? m.cause : 2'd0));
      chk("m_busy",  32'(busy), 32'(m.phase != 0));
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   32'(mem_if.mem_req), 32'd0);
    chk({tag, "_addr"},  mem_if.mem_addr, 32'd0);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_inst"},  inst_out, 32'h0000_0013);
    chk({tag, "_pc"},    inst_pc, 32'd0);
    chk({tag, "_fault"}, 32'(fetch_fault), 32'd0);
    chk({tag, "_cause"}, 32'(fault_cause), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
  endtask

  initial begin
    int n_req;
    int seen;
    reset = 1'b0; fetch_start = 1'b0; pc_in = 32'd0; flush = 1'b0; inst_ack = 1'b0;
    mem_if.mem_ready = 1'b0; mem_if.mem_rdata = 32'd0; mem_if.mem_err = 1'b0;
    repeat (2) @(negedge clk);
    cmp_on = 1'b1;
    chk_reset_vals("rst");
    reset = 1'b1;
    @(negedge clk);

    // Zero-wait fetch.
    fetch_start = 1'b1; pc_in = 32'h4;
    @(negedge clk);
    chk("zw_req", 32'(mem_if.mem_req), 32'd1);
    chk("zw_addr", mem_if.mem_addr, 32'h4);
    chk("zw_valid_early", 32'(inst_valid), 32'd0);
    fetch_start = 1'b0; mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'h0050_0093;
    @(negedge clk);
    chk("zw_valid", 32'(inst_valid), 32'd1);
    chk("zw_inst", inst_out, 32'h0050_0093);
    chk("zw_pc", inst_pc, 32'h4);
    chk("zw_req_fall", 32'(mem_if.mem_req), 32'd0);
    mem_if.mem_ready = 1'b0; inst_ack = 1'b1;
    @(negedge clk);
    chk("zw_idle", 32'(busy), 32'd0);
    inst_ack = 1'b0;

    // Misaligned PC.
    fetch_start = 1'b1; pc_in = 32'h6;
    @(negedge clk);
    fetch_start = 1'b0;
    chk("mis_fault", 32'(fetch_fault), 32'd1);
    chk("mis_cause", 32'(fault_cause), 32'd1);
    chk("mis_pc", inst_pc, 32'h6);
    chk("mis_req", 32'(mem_if.mem_req), 32'd0);
    chk("mis_addr", mem_if.mem_addr, 32'h4);
    fetch_start = 1'b1; pc_in = 32'h40;
    @(negedge clk);
    chk("mis_start_ignored", 32'(mem_if.mem_req), 32'd0);
    fetch_start = 1'b0; inst_ack = 1'b1;
    @(negedge clk);
    chk("mis_clear", 32'(fetch_fault), 32'd0);
    inst_ack = 1'b0;

    // Bus error.
    fetch_start = 1'b1; pc_in = 32'h100;
    @(negedge clk);
    chk("be_addr", mem_if.mem_addr, 32'h100);
    fetch_start = 1'b0;
    mem_if.mem_ready = 1'b1; mem_if.mem_err = 1'b1; mem_if.mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("be_cause", 32'(fault_cause), 32'd2);
    chk("be_inst_kept", inst_out, 32'h0050_0093);
    mem_if.mem_ready = 1'b0; mem_if.mem_err = 1'b0; inst_ack = 1'b1;
    @(negedge clk);
    inst_ack = 1'b0;

    // Timeout with MAX_WAIT = 4.
    fetch_start = 1'b1; pc_in = 32'h200;
    n_req = 0; seen = 0;
    for (int i = 0; i < 12 && seen == 0; i++) begin
      @(negedge clk);
      fetch_start = 1'b0;
      if (mem_if.mem_req) n_req++;
      if (fetch_fault) seen = 1;
    end
    chk("to_seen", 32'(seen), 32'd1);
    chk("to_req_cycles", 32'(n_req), 32'd4);
    chk("to_cause", 32'(fault_cause), 32'd3);
    inst_ack = 1'b1;
    @(negedge clk);
    inst_ack = 1'b0;

    // Flush in the first REQ cycle; data arrives three cycles later.
    fetch_start = 1'b1; pc_in = 32'h10;
    @(negedge clk);
    fetch_start = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_drain_req", 32'(mem_if.mem_req), 32'd1);
    chk("fl_drain_addr", mem_if.mem_addr, 32'h10);
    @(negedge clk);
    @(negedge clk);
    mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_if.mem_ready = 1'b0;
    chk("fl_idle", 32'(busy), 32'd0);
    chk("fl_novalid", 32'(inst_valid), 32'd0);
    chk("fl_nofault", 32'(fetch_fault), 32'd0);
    chk("fl_inst_kept", inst_out, 32'h0050_0093);

    // Back-to-back fetches, then reset mid-REQ.
    fetch_start = 1'b1; pc_in = 32'h20;
    @(negedge clk);
    fetch_start = 1'b0; mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'h1111_1111;
    @(negedge clk);
    mem_if.mem_ready = 1'b0;
    chk("bb_inst1", inst_out, 32'h1111_1111);
    @(negedge clk);
    chk("bb_stall_valid", 32'(inst_valid), 32'd1);
    inst_ack = 1'b1; fetch_start = 1'b1; pc_in = 32'h8;
    @(negedge clk);
    chk("bb_req", 32'(mem_if.mem_req), 32'd1);
    chk("bb_addr", mem_if.mem_addr, 32'h8);
    chk("bb_pc", inst_pc, 32'h8);
    inst_ack = 1'b0; fetch_start = 1'b0;
    mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'h2222_2222;
    @(negedge clk);
    chk("bb_inst2", inst_out, 32'h2222_2222);
    mem_if.mem_ready = 1'b0; inst_ack = 1'b1; fetch_start = 1'b1; pc_in = 32'hC;
    @(negedge clk);
    chk("bb_req2", 32'(mem_if.mem_req), 32'd1);
    inst_ack = 1'b0; fetch_start = 1'b0;
    #2 reset = 1'b0;
    #1 chk_reset_vals("mid");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
